instr_encoder: RTL and testbench

- Inverse of the pipeline's instruction decode stage: accepts decoded micro-op fields (ALU op code, register indices, 16-bit immediate, instruction kind) and packs them into 32-bit DLX instruction words.
- Writes each encoded word into instruction memory at consecutive word addresses.
- Used by the boot/program loader and by testbenches to build program images.
- Illegal field combinations are dropped and counted.

---
 rtl/instr_encoder_if.sv | 27 ++
 rtl/instr_encoder.sv | 137 +++++++++++++
 tb/tb_instr_encoder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: micro-op input channel and instruction-memory write channel
interface instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        kind;
    logic [3:0]        I;
    logic [4:0]        Rs1;
    logic [4:0]        Rs2;
    logic [4:0]        Rd;
    logic [15:0]       Iv;
    logic              i_write_enable;
    logic [ADDR_W-1:0] i_address;
    logic [31:0]       i_data_write;
    logic              i_write_ack;

    modport slave (
        input  in_valid, kind, I, Rs1, Rs2, Rd, Iv, i_write_ack,
        output in_ready, i_write_enable, i_address, i_data_write
    );

    modport master (
        output in_valid, kind, I, Rs1, Rs2, Rd, Iv, i_write_ack,
        input  in_ready, i_write_enable, i_address, i_data_write
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded micro-op fields into DLX words and writes them to instruction memory
module instr_encoder #(
    parameter int ADDR_W = 32,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              finish,
    instr_encoder_if.slave    bus,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] words,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, words_q, words_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [31:0]       data_q, data_d, word;
    logic              we_q, we_d, err_q, err_d, done_q, done_d;
    logic [5:0]        func, iop;
    logic              alu_ok, legal, ack_ok, accept;

    assign bus.in_ready       = (state_q == RUN) && (!we_q || bus.i_write_ack);
    assign bus.i_write_enable = we_q;
    assign bus.i_address      = addr_q;
    assign bus.i_data_write   = data_q;
    assign err                = err_q;
    assign err_cnt            = err_cnt_q;
    assign words              = words_q;
    assign done               = done_q;
    assign ack_ok             = we_q && bus.i_write_ack;
    assign accept             = bus.in_valid && bus.in_ready;

    // Map the decode-stage ALU op code to R-type func and I-type opcode
    always_comb begin
        func   = 6'h00;
        iop    = 6'h00;
        alu_ok = 1'b1;
        case (bus.I)
            4'd1:    begin func = 6'h20; iop = 6'h08; end
            4'd2:    begin func = 6'h22; iop = 6'h0a; end
            4'd3:    begin func = 6'h24; iop = 6'h0c; end
            4'd4:    begin func = 6'h25; iop = 6'h0d; end
            4'd5:    begin func = 6'h26; iop = 6'h0e; end
            4'd6:    begin func = 6'h04; iop = 6'h14; end
            4'd7:    begin func = 6'h06; iop = 6'h16; end
            4'd14:   begin func = 6'h07; iop = 6'h17; end
            4'd10:   begin func = 6'h28; iop = 6'h18; end
            4'd11:   begin func = 6'h2c; iop = 6'h1c; end
            4'd12:   begin func = 6'h2a; iop = 6'h1a; end
            4'd13:   begin func = 6'h29; iop = 6'h19; end
            default: alu_ok = 1'b0;
        endcase
    end

    // Assemble the instruction word for each kind and flag illegal combinations
    always_comb begin
        legal = (bus.kind <= 3'd1) ? alu_ok :
                (bus.kind == 3'd4) ? (bus.I == 4'd8 || bus.I == 4'd9) : 1'b1;
        case (bus.kind)
            3'd0:    word = {6'h00, bus.Rs1, bus.Rs2, bus.Rd, 5'd0, func};
            3'd1:    word = {iop, bus.Rs1, bus.Rd, bus.Iv};
            3'd2:    word = {6'h23, bus.Rs1, bus.Rd, bus.Iv};
            3'd3:    word = {6'h2b, bus.Rs1, bus.Rs2, bus.Iv};
            3'd4:    word = {(bus.I == 4'd9) ? 6'h05 : 6'h04, bus.Rs1, 5'd0, bus.Iv};
            3'd5:    word = {6'h12, 10'd0, bus.Iv};
            3'd6:    word = {6'h13, 10'd0, bus.Iv};
            default: word = {6'h0f, 5'd0, bus.Rd, bus.Iv};
        endcase
    end

    // Next-state: control FSM, write handshake, address/word/error bookkeeping
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        words_d   = words_q;
        err_cnt_d = err_cnt_q;
        data_d    = data_q;
        we_d      = we_q;
        err_d     = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d   = RUN;
                addr_d    = {start_addr[ADDR_W-1:2], 2'b00};
                words_d   = '0;
                err_cnt_d = '0;
            end
            RUN: if (finish) state_d = DRAIN;
            DRAIN: if (!we_q || ack_ok) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (ack_ok) begin
            addr_d  = addr_q + ADDR_W'(4);
            words_d = words_q + ADDR_W'(1);
            we_d    = 1'b0;
        end
        if (accept && legal) begin
            we_d   = 1'b1;
            data_d = word;
        end
        if (accept && !legal) begin
            err_d     = 1'b1;
            err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_W'(1);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            words_q   <= '0;
            err_cnt_q <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            words_q   <= words_d;
            err_cnt_q <= err_cnt_d;
            data_q    <= data_d;
            we_q      <= we_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven vectors with a write scoreboard plus hand-written handshake sequences
module tb_instr_encoder;
    localparam int AW = 32;

    typedef struct {
        logic [2:0]  k;
        logic [3:0]  i;
        logic [4:0]  s1, s2, d;
        logic [15:0] iv;
        logic        ok;
        logic [31:0] w;
    } vec_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] w;
    } exp_t;

    logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0, finish = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          err, done;
    logic [7:0]    err_cnt;
    logic [AW-1:0] words;
    logic          ack_auto = 1'b0, ack_rand = 1'b0, mon_on = 1'b0;
    logic          err_exp [2];
    logic [31:0]   model_addr = '0;
    int            errors = 0, checks = 0, cyc = 0;
    exp_t          sbq [$];
    vec_t          tbl [17];

    instr_encoder_if #(.ADDR_W(AW)) bus ();

    instr_encoder #(.ADDR_W(AW), .ERR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .finish(finish), .bus(bus), .err(err), .err_cnt(err_cnt),
        .words(words), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (ack_auto) bus.i_write_ack = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.i_write_enable && bus.i_write_ack) begin
                exp_t e;
                if (sbq.size() == 0) chk("unexpected_write", 64'(bus.i_data_write), 64'hdead);
                else begin
                    e = sbq.pop_front();
                    chk("wr_addr", 64'(bus.i_address), 64'(e.a));
                    chk("wr_data", 64'(bus.i_data_write), 64'(e.w));
                end
            end
            chk("err_pulse", 64'(err), 64'(err_exp[cyc % 2]));
            err_exp[cyc % 2] = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.kind = v.k; bus.I = v.i; bus.Rs1 = v.s1; bus.Rs2 = v.s2; bus.Rd = v.d; bus.Iv = v.iv;
        bus.in_valid = 1'b1;
    endtask

    task automatic wait_accept(input vec_t v);
        logic got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = bus.in_ready;
        end
        chk("accepted", 64'(got), 64'd1);
        if (got && v.ok) begin
            sbq.push_back({model_addr, v.w});
            model_addr += 32'd4;
        end else if (got) err_exp[(cyc + 1) % 2] = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input vec_t v);
        drive(v);
        wait_accept(v);
    endtask

    task automatic do_start(input logic [31:0] a);
        start = 1'b1;
        start_addr = a;
        tick();
        start = 1'b0;
        model_addr = a & ~32'h3;
    endtask

    task automatic drain();
        logic ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = (sbq.size() == 0) && !bus.i_write_enable;
        end
        chk("drained", 64'(ok), 64'd1);
    endtask

    task automatic finish_wait();
        logic got = 1'b0;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = done;
        end
        chk("done_seen", 64'(got), 64'd1);
        tick();
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_ready"}, 64'(bus.in_ready), 64'd0);
        chk({p, "_we"}, 64'(bus.i_write_enable), 64'd0);
        chk({p, "_addr"}, 64'(bus.i_address), 64'd0);
        chk({p, "_data"}, 64'(bus.i_data_write), 64'd0);
        chk({p, "_err"}, 64'(err), 64'd0);
        chk({p, "_errcnt"}, 64'(err_cnt), 64'd0);
        chk({p, "_words"}, 64'(words), 64'd0);
        chk({p, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a_addr;
        int legal_n = 0;
        tbl[0]  = '{3'd0, 4'd1,  5'd2,  5'd3, 5'd4,  16'h0000, 1'b1, 32'h00432020};
        tbl[1]  = '{3'd1, 4'd1,  5'd1,  5'd0, 5'd5,  16'hFFFF, 1'b1, 32'h2025FFFF};
        tbl[2]  = '{3'd2, 4'd0,  5'd1,  5'd0, 5'd2,  16'h0008, 1'b1, 32'h8C220008};
        tbl[3]  = '{3'd3, 4'd0,  5'd3,  5'd4, 5'd0,  16'h0010, 1'b1, 32'hAC640010};
        tbl[4]  = '{3'd4, 4'd8,  5'd5,  5'd7, 5'd9,  16'h0020, 1'b1, 32'h10A00020};
        tbl[5]  = '{3'd4, 4'd9,  5'd0,  5'd0, 5'd0,  16'hFFFC, 1'b1, 32'h1400FFFC};
        tbl[6]  = '{3'd5, 4'd3,  5'd5,  5'd6, 5'd7,  16'h1234, 1'b1, 32'h48001234};
        tbl[7]  = '{3'd6, 4'd0,  5'd0,  5'd0, 5'd0,  16'h8000, 1'b1, 32'h4C008000};
        tbl[8]  = '{3'd7, 4'd0,  5'd31, 5'd0, 5'd7,  16'hABCD, 1'b1, 32'h3C07ABCD};
        tbl[9]  = '{3'd0, 4'd14, 5'd31, 5'd1, 5'd31, 16'hFFFF, 1'b1, 32'h03E1F807};
        tbl[10] = '{3'd1, 4'd12, 5'd2,  5'd0, 5'd3,  16'h0001, 1'b1, 32'h68430001};
        tbl[11] = '{3'd0, 4'd15, 5'd1,  5'd2, 5'd3,  16'h0000, 1'b0, 32'h0};
        tbl[12] = '{3'd1, 4'd0,  5'd1,  5'd2, 5'd3,  16'h0005, 1'b0, 32'h0};
        tbl[13] = '{3'd4, 4'd1,  5'd1,  5'd0, 5'd0,  16'h0004, 1'b0, 32'h0};
        tbl[14] = '{3'd0, 4'd10, 5'd1,  5'd2, 5'd3,  16'h0000, 1'b1, 32'h00221828};
        tbl[15] = '{3'd1, 4'd8,  5'd1,  5'd2, 5'd3,  16'h0000, 1'b0, 32'h0};
        tbl[16] = '{3'd1, 4'd7,  5'd4,  5'd0, 5'd4,  16'h0003, 1'b1, 32'h58840003};
        err_exp[0] = 1'b0;
        err_exp[1] = 1'b0;
        bus.in_valid = 1'b0; bus.kind = '0; bus.I = '0; bus.Rs1 = '0; bus.Rs2 = '0;
        bus.Rd = '0; bus.Iv = '0; bus.i_write_ack = 1'b0;
        #12;
        chk_zero("rst");
        @(negedge clk);
        reset_n = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'(bus.in_ready), 64'd0);
        ack_auto = 1'b1;
        tick();
        do_start(32'h100);
        send(tbl[0]);
        drain();
        chk("basic_words", 64'(words), 64'd1);
        ack_rand = 1'b1;
        tick();
        legal_n = 1;
        for (int i = 1; i < 17; i++) begin
            send(tbl[i]);
            if (tbl[i].ok) legal_n++;
        end
        drain();
        ack_rand = 1'b0;
        @(negedge clk);
        chk("table_words", 64'(words), 64'(legal_n));
        chk("table_errcnt", 64'(err_cnt), 64'd4);
        ack_auto = 1'b0;
        bus.i_write_ack = 1'b0;
        tick();
        send(tbl[0]);
        a_addr = model_addr - 32'd4;
        drive(tbl[1]);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_we", 64'(bus.i_write_enable), 64'd1);
            chk("bp_data", 64'(bus.i_data_write), 64'(tbl[0].w));
            chk("bp_addr", 64'(bus.i_address), 64'(a_addr));
        end
        tick();
        bus.i_write_ack = 1'b1;
        wait_accept(tbl[1]);
        @(negedge clk);
        chk("b2b_we", 64'(bus.i_write_enable), 64'd1);
        chk("b2b_data", 64'(bus.i_data_write), 64'(tbl[1].w));
        ack_auto = 1'b1;
        tick();
        finish_wait();
        do_start(32'h200);
        send(tbl[11]);
        @(negedge clk);
        chk("ill_we", 64'(bus.i_write_enable), 64'd0);
        chk("ill_cnt", 64'(err_cnt), 64'd1);
        chk("ill_addr", 64'(bus.i_address), 64'h200);
        tick();
        for (int n = 0; n < 300; n++) send(tbl[11]);
        @(negedge clk);
        @(negedge clk);
        chk("sat_cnt", 64'(err_cnt), 64'd255);
        chk("sat_words", 64'(words), 64'd0);
        tick();
        send(tbl[0]);
        drain();
        chk("ill_words", 64'(words), 64'd1);
        tick();
        finish_wait();
        @(negedge clk);
        ack_auto = 1'b0;
        bus.i_write_ack = 1'b1;
        tick();
        do_start(32'hFFFF_FFFF);
        send(tbl[2]);
        send(tbl[3]);
        bus.i_write_ack = 1'b0;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            chk("drain_done", 64'(done), 64'd0);
            chk("drain_we", 64'(bus.i_write_enable), 64'd1);
        end
        tick();
        bus.i_write_ack = 1'b1;
        @(negedge clk);
        chk("ack_cycle_done", 64'(done), 64'd0);
        tick();
        bus.i_write_ack = 1'b0;
        @(negedge clk);
        chk("wrap_done", 64'(done), 64'd1);
        chk("wrap_words", 64'(words), 64'd2);
        @(negedge clk);
        chk("post_done", 64'(done), 64'd0);
        chk("post_ready", 64'(bus.in_ready), 64'd0);
        tick();
        do_start(32'h40);
        send(tbl[0]);
        @(negedge clk);
        chk("rm_we", 64'(bus.i_write_enable), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("rm");
        sbq.delete();
        err_exp[0] = 1'b0;
        err_exp[1] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        drive(tbl[0]);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("rm_ready", 64'(bus.in_ready), 64'd0);
            chk("rm_idle_we", 64'(bus.i_write_enable), 64'd0);
        end
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
